// File: rtl/fcvt_issue_if.sv
// Request and writeback buses of the convert issue controller.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1. A source holds its payload stable while valid && !ready, and ready never depends on a transfer completing in the same cycle.
interface fcvt_issue_if #(
    parameter int TAGW = 5
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_a;
    logic [TAGW-1:0] req_tag;
    logic            wb_valid;
    logic            wb_ready;
    logic [31:0]     wb_data;
    logic [TAGW-1:0] wb_tag;

    // master: FP pipeline / writeback side; slave: the controller
    modport master (
        output req_valid, req_a, req_tag, wb_ready,
        input  req_ready, wb_valid, wb_data, wb_tag
    );
    modport slave (
        input  req_valid, req_a, req_tag, wb_ready,
        output req_ready, wb_valid, wb_data, wb_tag
    );
endinterface

// File: rtl/fcvt_issue_ctrl.sv
// Issue/retire controller for a fixed-latency float->int convert unit.
// Credits cover FIFO entries plus in-flight ops, so every retiring result has a slot waiting.
module fcvt_issue_ctrl #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    fcvt_issue_if.slave bus,
    input  logic        flush,
    output logic        cvt_valid,
    output logic [31:0] cvt_a,
    input  logic        cvt_valid_o,
    input  logic [31:0] cvt_y,
    output logic        busy,
    output logic        err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [LAT-1:0]   tv_q, tv_d;
    logic [TAGW-1:0]  tt_q [LAT];
    logic [TAGW-1:0]  tt_d [LAT];
    logic [LAT-1:0]   fhist_q, fhist_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [TAGW+31:0] mem_q [DEPTH];
    logic             err_q, err_d;

    logic [CW:0]      occ;
    logic [LAT:0]     tv_sh, fh_sh;
    logic             fire, leave, recent_flush, full, pop, push_req, push;

    always_comb begin
        occ           = {1'b0, count_q} + {1'b0, inflight_q};
        bus.req_ready = (occ < (CW+1)'(DEPTH)) && !flush;
        fire          = bus.req_valid && bus.req_ready;
        cvt_valid     = fire;
        cvt_a         = bus.req_a;

        leave         = tv_q[LAT-1];
        // stale results from ops killed by a flush may still emerge for LAT cycles
        recent_flush  = flush || (|fhist_q);
        full          = (count_q == CW'(DEPTH));
        bus.wb_valid  = (count_q != '0);
        bus.wb_data   = mem_q[rd_q][31:0];
        bus.wb_tag    = mem_q[rd_q][TAGW+31:32];
        pop           = bus.wb_valid && bus.wb_ready;
        push_req      = cvt_valid_o && leave && !flush;
        push          = push_req && (!full || pop);

        tv_sh   = {tv_q, fire};
        tv_d    = flush ? '0 : tv_sh[LAT-1:0];
        fh_sh   = {fhist_q, flush};
        fhist_d = fh_sh[LAT-1:0];
        tt_d[0] = bus.req_tag;
        for (int i = 1; i < LAT; i++) begin
            tt_d[i] = tt_q[i-1];
        end

        inflight_d = flush ? '0 : inflight_q + CW'(fire) - CW'(leave);
        count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
        wr_d       = flush ? '0 : wr_q + PW'(push);
        rd_d       = flush ? '0 : rd_q + PW'(pop);

        err_d = err_q
              | (push_req && full && !pop)
              | (cvt_valid_o && !leave && !recent_flush)
              | (leave && !cvt_valid_o);

        busy = (occ != '0);
        err  = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv_q       <= '0;
            fhist_q    <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                tt_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tv_q       <= tv_d;
            fhist_q    <= fhist_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            for (int i = 0; i < LAT; i++) begin
                tt_q[i] <= tt_d[i];
            end
            if (push) begin
                mem_q[wr_q] <= {tt_q[LAT-1], cvt_y};
            end
        end
    end
endmodule
